// File: rtl/caesar_sched.sv
// caesar_sched: round-robin scheduler that shares one Caesar decrypt engine
// among NUM_REQ byte-stream requesters. Each grant covers one burst (capped at
// MAX_BURST beats), feeds the engine with the granted requester's latched key,
// and tags engine results with requester ID and last-beat flag.
module caesar_sched #(
  parameter int NUM_REQ   = 4,
  parameter int D_WIDTH   = 8,
  parameter int KEY_WIDTH = 16,
  parameter int ID_WIDTH  = 2,
  parameter int ENG_LAT   = 1,
  parameter int MAX_BURST = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  input  logic [NUM_REQ*D_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       cfg_we,
  input  logic [ID_WIDTH-1:0]        cfg_id,
  input  logic [KEY_WIDTH-1:0]       cfg_key,
  output logic                       eng_valid,
  output logic [D_WIDTH-1:0]         eng_data,
  output logic [KEY_WIDTH-1:0]       eng_key,
  input  logic                       eng_valid_in,
  input  logic [D_WIDTH-1:0]         eng_data_in,
  output logic                       rsp_valid,
  output logic [D_WIDTH-1:0]         rsp_data,
  output logic [ID_WIDTH-1:0]        rsp_id,
  output logic                       rsp_last,
  output logic                       busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam int IDP_W = ENG_LAT * ID_WIDTH;

  typedef enum logic {IDLE, BURST} state_t;

  state_t               state;
  logic [ID_WIDTH-1:0]  ptr;
  logic [ID_WIDTH-1:0]  gnt_id;
  logic [KEY_WIDTH-1:0] cur_key;
  logic [CNT_W-1:0]     beat_cnt;
  logic [KEY_WIDTH-1:0] key_tab [NUM_REQ];

  logic                 found;
  logic [ID_WIDTH-1:0]  winner;
  logic [ID_WIDTH-1:0]  idx;
  logic                 accept;
  logic                 last_eff;
  logic [ID_WIDTH-1:0]  nxt_ptr;

  // Tag travelling alongside eng_valid, then ENG_LAT stages to meet the result
  logic [ID_WIDTH-1:0]  eng_tag_id;
  logic                 eng_tag_last;
  logic [ENG_LAT-1:0]   tag_v;
  logic [ENG_LAT-1:0]   tag_last;
  logic [IDP_W-1:0]     tag_id;
  logic                 tag_hit;

  assign accept   = (state == BURST) && req_valid[gnt_id];
  assign last_eff = req_last[gnt_id] || (beat_cnt == CNT_W'(MAX_BURST - 1));
  assign nxt_ptr  = (gnt_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_id + ID_WIDTH'(1);
  assign eng_key  = cur_key;
  assign tag_hit  = eng_valid_in && tag_v[ENG_LAT-1];
  assign busy     = (state == BURST) || eng_valid || (|tag_v);

  // Round-robin search: first valid requester at or after ptr, wrapping upward
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    idx    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ID_WIDTH'((32'(ptr) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Ready only toward the granted requester while a burst is open
  always_comb begin
    req_ready = '0;
    if (state == BURST) req_ready[gnt_id] = 1'b1;
  end

  // Key table; a grant reads the pre-write value on a same-cycle write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) key_tab <= '{default: '0};
    else if (cfg_we) key_tab[cfg_id] <= cfg_key;
  end

  // Grant FSM and registered engine-side outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ptr          <= '0;
      gnt_id       <= '0;
      cur_key      <= '0;
      beat_cnt     <= '0;
      eng_valid    <= 1'b0;
      eng_data     <= '0;
      eng_tag_id   <= '0;
      eng_tag_last <= 1'b0;
    end else begin
      eng_valid    <= 1'b0;
      eng_data     <= '0;
      eng_tag_id   <= '0;
      eng_tag_last <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            state    <= BURST;
            gnt_id   <= winner;
            cur_key  <= key_tab[winner];
            beat_cnt <= '0;
          end
        end
        BURST: begin
          if (accept) begin
            eng_valid    <= 1'b1;
            eng_data     <= req_data[gnt_id*D_WIDTH +: D_WIDTH];
            eng_tag_id   <= gnt_id;
            eng_tag_last <= last_eff;
            beat_cnt     <= beat_cnt + CNT_W'(1);
            if (last_eff) begin
              state <= IDLE;
              ptr   <= nxt_ptr;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag delay line and registered response; untagged engine results are dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_v     <= '0;
      tag_last  <= '0;
      tag_id    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_last  <= 1'b0;
    end else begin
      // Shift-in form keeps the delay line valid for any ENG_LAT >= 1
      tag_v     <= (tag_v << 1) | ENG_LAT'(eng_valid);
      tag_last  <= (tag_last << 1) | ENG_LAT'(eng_tag_last);
      tag_id    <= (tag_id << ID_WIDTH) | IDP_W'(eng_tag_id);
      rsp_valid <= tag_hit;
      if (tag_hit) begin
        rsp_data <= eng_data_in;
        rsp_id   <= tag_id[IDP_W-1 -: ID_WIDTH];
        rsp_last <= tag_last[ENG_LAT-1];
      end else begin
        rsp_data <= '0;
        rsp_id   <= '0;
        rsp_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_caesar_sched.sv
// Testbench for caesar_sched: requester stream sources, a single-cycle
// Caesar engine model, and a response scoreboard fed at beat acceptance.
module tb_caesar_sched;

  localparam int NUM_REQ   = 4;
  localparam int D_WIDTH   = 8;
  localparam int KEY_WIDTH = 16;
  localparam int ID_WIDTH  = 2;
  localparam int ENG_LAT   = 1;
  localparam int MAX_BURST = 16;

  logic                       clk = 1'b0;
  logic                       reset;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_last;
  logic [NUM_REQ*D_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       cfg_we;
  logic [ID_WIDTH-1:0]        cfg_id;
  logic [KEY_WIDTH-1:0]       cfg_key;
  logic                       eng_valid;
  logic [D_WIDTH-1:0]         eng_data;
  logic [KEY_WIDTH-1:0]       eng_key;
  logic                       eng_valid_in;
  logic [D_WIDTH-1:0]         eng_data_in;
  logic                       rsp_valid;
  logic [D_WIDTH-1:0]         rsp_data;
  logic [ID_WIDTH-1:0]        rsp_id;
  logic                       rsp_last;
  logic                       busy;

  caesar_sched #(
    .NUM_REQ  (NUM_REQ),
    .D_WIDTH  (D_WIDTH),
    .KEY_WIDTH(KEY_WIDTH),
    .ID_WIDTH (ID_WIDTH),
    .ENG_LAT  (ENG_LAT),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .cfg_we      (cfg_we),
    .cfg_id      (cfg_id),
    .cfg_key     (cfg_key),
    .eng_valid   (eng_valid),
    .eng_data    (eng_data),
    .eng_key     (eng_key),
    .eng_valid_in(eng_valid_in),
    .eng_data_in (eng_data_in),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_id      (rsp_id),
    .rsp_last    (rsp_last),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Single-cycle decrypt engine sharing the scheduler reset
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      eng_valid_in <= 1'b0;
      eng_data_in  <= '0;
    end else begin
      eng_valid_in <= eng_valid;
      eng_data_in  <= eng_data - eng_key[D_WIDTH-1:0];
    end
  end

  typedef struct {
    int             id;
    logic [7:0]     data;
    logic           last;
    logic [15:0]    key;
  } beat_t;

  typedef struct {
    int             id;
    logic [7:0]     data;
    logic           last;
    int             acc_cyc;
  } exp_t;

  beat_t bq[$];
  exp_t  sb[$];
  int    glog[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    n_acc   = 0;
  int    bcnt    = 0;
  bit    in_burst  = 1'b0;
  bit    prev_last = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Response side: every result must match the oldest accepted beat
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("rsp_data", 32'(rsp_data), 32'(e.data));
        check_eq("rsp_id", 32'(rsp_id), 32'(e.id));
        check_eq("rsp_last", 32'(rsp_last), 32'(e.last));
        check_eq("rsp_latency", 32'(cyc - e.acc_cyc), 32'd2);
      end
    end else begin
      check_eq("rsp_idle_data", 32'(rsp_data), 32'd0);
    end
  end

  function automatic int find_front(input int id);
    for (int j = 0; j < bq.size(); j++)
      if (bq[j].id == id) return j;
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      int f;
      f = find_front(i);
      if (f >= 0) begin
        req_valid[i] = 1'b1;
        req_last[i]  = bq[f].last;
        req_data[i*D_WIDTH +: D_WIDTH] = bq[f].data;
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        req_data[i*D_WIDTH +: D_WIDTH] = '0;
      end
    end
  endtask

  task automatic step();
    logic [NUM_REQ-1:0] acc;
    @(negedge clk);
    check_eq("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
    if (prev_last) check_eq("idle_gap", 32'(req_ready), 32'd0);
    if (eng_valid !== 1'b1) check_eq("eng_data_idle", 32'(eng_data), 32'd0);
    prev_last = 1'b0;
    acc = req_ready & req_valid;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i]) begin
        int    f;
        beat_t b;
        exp_t  e;
        logic  le;
        f = find_front(i);
        if (f >= 0) begin
          b = bq[f];
          bq.delete(f);
          if (!in_burst) begin
            glog.push_back(i);
            in_burst = 1'b1;
          end
          le = b.last || (bcnt == MAX_BURST - 1);
          e.id      = i;
          e.data    = b.data - b.key[7:0];
          e.last    = le;
          e.acc_cyc = cyc + 1;
          sb.push_back(e);
          n_acc++;
          bcnt++;
          if (le) begin
            bcnt      = 0;
            in_burst  = 1'b0;
            prev_last = 1'b1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic add_beat(input int id, input logic [7:0] d, input logic l, input logic [15:0] k);
    beat_t b;
    b.id = id; b.data = d; b.last = l; b.key = k;
    bq.push_back(b);
  endtask

  task automatic cfg_write(input int id, input logic [15:0] k);
    cfg_we  = 1'b1;
    cfg_id  = ID_WIDTH'(id);
    cfg_key = k;
    step();
    cfg_we  = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int g = 0; g < 400 && (bq.size() != 0 || sb.size() != 0); g++) step();
    check_eq(tag, 32'(bq.size() + sb.size()), 32'd0);
  endtask

  task automatic check_grants(input string tag, input int n, input int g0, input int g1,
                              input int g2, input int g3);
    int e[4];
    e = '{g0, g1, g2, g3};
    check_eq({tag, "_count"}, 32'(glog.size()), 32'(n));
    for (int i = 0; i < n; i++)
      check_eq(tag, (i < glog.size()) ? 32'(glog[i]) : 32'hFFFF_FFFF, 32'(e[i]));
    glog.delete();
  endtask

  task automatic check_quiet(input string tag);
    check_eq(tag, 32'({req_ready, eng_valid, eng_data, rsp_valid, rsp_data, rsp_id, rsp_last, busy}),
             32'd0);
    check_eq({tag, "_key"}, 32'(eng_key), 32'd0);
  endtask

  initial begin
    int n0;
    reset = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0;
    cfg_we = 1'b0; cfg_id = '0; cfg_key = '0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset_outputs");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Round robin across 0, 2, 3 with continuous single-beat bursts
    cfg_write(0, 16'd1);
    cfg_write(2, 16'd2);
    cfg_write(3, 16'd4);
    add_beat(0, 8'h20, 1'b1, 16'd1);
    add_beat(0, 8'h21, 1'b1, 16'd1);
    add_beat(2, 8'h30, 1'b1, 16'd2);
    add_beat(3, 8'h40, 1'b1, 16'd4);
    drive();
    drain("rr_drain");
    check_grants("rr_order", 4, 0, 2, 3, 0);

    // Single burst "DEF" with key 3 -> "ABC"
    cfg_write(1, 16'd3);
    add_beat(1, "D", 1'b0, 16'd3);
    add_beat(1, "E", 1'b0, 16'd3);
    add_beat(1, "F", 1'b1, 16'd3);
    drive();
    step();
    step();
    check_eq("busy_burst", 32'(busy), 32'd1);
    drain("single_drain");
    check_eq("busy_idle", 32'(busy), 32'd0);
    check_grants("single_order", 1, 1, 0, 0, 0);

    // Burst cap: 20 beats from req 0 split 16 + 4 around req 1
    for (int k = 0; k < 20; k++) add_beat(0, 8'(8'h50 + k), 1'(k == 19), 16'd1);
    add_beat(1, 8'h70, 1'b1, 16'd3);
    drive();
    drain("cap_drain");
    check_grants("cap_order", 3, 0, 1, 0, 0);

    // Key write mid-burst only affects the following grant
    cfg_write(2, 16'd1);
    for (int k = 0; k < 4; k++) add_beat(2, 8'(8'h80 + k), 1'(k == 3), 16'd1);
    for (int k = 0; k < 3; k++) add_beat(2, 8'(8'h88 + k), 1'(k == 2), 16'd5);
    drive();
    step();
    step();
    step();
    cfg_write(2, 16'd5);
    drain("keylatch_drain");
    check_grants("keylatch_order", 2, 2, 2, 0, 0);

    // Mod-256 wrap with upper key bits set; same-cycle write at grant is not seen
    cfg_write(3, 16'hAB03);
    add_beat(3, 8'h01, 1'b1, 16'hAB03);
    drive();
    cfg_write(3, 16'h0009);
    drain("wrap_drain");
    add_beat(3, 8'h01, 1'b1, 16'h0009);
    drive();
    drain("wrap2_drain");
    add_beat(0, 8'h00, 1'b1, 16'd1);
    drive();
    drain("ptr_move_drain");
    check_grants("wrap_order", 3, 3, 3, 0, 0);

    // Reset one cycle after an accept; in-flight beats must vanish
    for (int k = 0; k < 8; k++) add_beat(2, 8'(8'h90 + k), 1'(k == 7), 16'd5);
    drive();
    n0 = n_acc;
    for (int g = 0; g < 20 && n_acc == n0; g++) step();
    check_eq("rst_first_accept", 32'(n_acc - n0), 32'd1);
    step();
    reset = 1'b1;
    bq.delete();
    sb.delete();
    glog.delete();
    bcnt = 0;
    in_burst = 1'b0;
    prev_last = 1'b0;
    drive();
    #1;
    check_quiet("midrst_outputs");
    repeat (2) @(posedge clk);
    #1;
    check_quiet("midrst_hold");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    repeat (4) step();
    check_eq("post_rst_busy", 32'(busy), 32'd0);
    add_beat(1, 8'h33, 1'b1, 16'd0);
    add_beat(0, 8'h44, 1'b1, 16'd0);
    drive();
    drain("post_rst_drain");
    check_grants("post_rst_order", 2, 0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got %0d cycles", cyc);
    $fatal(1, "timeout");
  end

endmodule
